// File: rtl/hamming_pkg.sv
// Shared Hamming(11,7) definitions: widths, bit-position tables and data extraction.
// Used by both the encoder and the decoder so the bit layout lives in one place.
package hamming_pkg;

  localparam int DATA_W = 7;
  localparam int CODE_W = 11;
  localparam int SYN_W  = 4;

  // x[k] lives at codeword position DATA_POS[k]; check bits sit at powers of two.
  localparam int DATA_POS  [1:DATA_W]  = '{3, 5, 6, 7, 9, 10, 11};
  localparam int CHECK_POS [0:SYN_W-1] = '{1, 2, 4, 8};

  function automatic logic [DATA_W:1] extract_data(input logic [CODE_W:1] cw);
    logic [DATA_W:1] d;
    d = '0;
    for (int k = 1; k <= DATA_W; k++) begin
      d[k] = cw[DATA_POS[k]];
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome: XOR of the position indices of every set codeword bit.
// Zero latency; no flow control of its own.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W:1]  i_code,
  output logic [SYN_W-1:0] o_syn
);

  always_comb begin
    o_syn = '0;
    for (int i = 1; i <= CODE_W; i++) begin
      if (i_code[i]) begin
        o_syn = o_syn ^ SYN_W'(i);
      end
    end
  end

endmodule

// File: rtl/hamming_dec.sv
// Hamming(11,7) decoder with error counters; 2-cycle latency, 1 word/cycle.
// Both stages advance on en = !out_valid || out_ready; in_ready = en, so a stall holds everything.
module hamming_dec
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [11:1]       z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:1]        x,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [3:0]        syndrome,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  logic              w_en;
  logic              w_hs;
  logic [SYN_W-1:0]  w_syn;
  logic [CODE_W:1]   w_fixed;
  logic              w_is_corr;
  logic              w_is_uncorr;

  logic              r_s1_vld;
  logic [CODE_W:1]   r_s1_z;
  logic [SYN_W-1:0]  r_s1_syn;
  logic              r_out_vld;
  logic [DATA_W:1]   r_x;
  logic              r_corr;
  logic              r_uncorr;
  logic [SYN_W-1:0]  r_syn;
  logic [CNT_W-1:0]  r_cnt_corr;
  logic [CNT_W-1:0]  r_cnt_uncorr;

  assign w_en     = !r_out_vld || out_ready;
  assign w_hs     = r_out_vld && out_ready;
  assign in_ready = w_en;

  hamming_syndrome u_syn (
    .i_code (z),
    .o_syn  (w_syn)
  );

  assign w_is_corr   = (r_s1_syn != '0) && (r_s1_syn <= SYN_W'(CODE_W));
  assign w_is_uncorr = (r_s1_syn > SYN_W'(CODE_W));

  // Only syndromes 1..11 match a position, so 0 and 12..15 pass through unchanged.
  always_comb begin
    w_fixed = r_s1_z;
    for (int i = 1; i <= CODE_W; i++) begin
      if (r_s1_syn == SYN_W'(i)) begin
        w_fixed[i] = ~r_s1_z[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_z    <= '0;
      r_s1_syn  <= '0;
      r_out_vld <= 1'b0;
      r_x       <= '0;
      r_corr    <= 1'b0;
      r_uncorr  <= 1'b0;
      r_syn     <= '0;
    end else if (w_en) begin
      r_s1_vld  <= in_valid;
      r_s1_z    <= z;
      r_s1_syn  <= w_syn;
      r_out_vld <= r_s1_vld;
      r_x       <= extract_data(w_fixed);
      r_corr    <= r_s1_vld && w_is_corr;
      r_uncorr  <= r_s1_vld && w_is_uncorr;
      r_syn     <= r_s1_syn;
    end
  end

  // Clear outranks a simultaneous increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_cnt_corr   <= '0;
      r_cnt_uncorr <= '0;
    end else begin
      if (w_hs && r_corr && (r_cnt_corr != '1)) begin
        r_cnt_corr <= r_cnt_corr + CNT_W'(1);
      end
      if (w_hs && r_uncorr && (r_cnt_uncorr != '1)) begin
        r_cnt_uncorr <= r_cnt_uncorr + CNT_W'(1);
      end
    end
  end

  assign out_valid  = r_out_vld;
  assign x          = r_x;
  assign err_corr   = r_corr;
  assign err_uncorr = r_uncorr;
  assign syndrome   = r_syn;
  assign cnt_corr   = r_cnt_corr;
  assign cnt_uncorr = r_cnt_uncorr;

endmodule

// File: tb/tb_hamming_dec.sv
// Directed bench for hamming_dec: known codewords, stall behaviour, counter saturation/clear, reset.
module tb_hamming_dec;

  localparam int CNT_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [11:1]       z;
  logic              out_valid;
  logic              out_ready;
  logic [7:1]        x;
  logic              err_corr;
  logic              err_uncorr;
  logic [3:0]        syndrome;
  logic              clr_cnt;
  logic [CNT_W-1:0]  cnt_corr;
  logic [CNT_W-1:0]  cnt_uncorr;

  int checks = 0;
  int errors = 0;

  hamming_dec #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .z          (z),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .x          (x),
    .err_corr   (err_corr),
    .err_uncorr (err_uncorr),
    .syndrome   (syndrome),
    .clr_cnt    (clr_cnt),
    .cnt_corr   (cnt_corr),
    .cnt_uncorr (cnt_uncorr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word, leave it on the output register (out_valid=1) for the caller to check.
  task automatic push_word(input logic [11:1] w);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    z         = w;
    tick();
    in_valid  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0; z = '0;
    tick();
    tick();
    checks++;
    if ({out_valid, in_ready, x, err_corr, err_uncorr, syndrome} !== {1'b0, 1'b1, 7'h00, 1'b0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b rdy=%b x=%h c=%b u=%b s=%0d want 0 1 00 0 0 0",
               out_valid, in_ready, x, err_corr, err_uncorr, syndrome);
    end
    checks++;
    if ({cnt_corr, cnt_uncorr} !== '0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", cnt_corr, cnt_uncorr);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ready: got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_clean();
    out_ready = 1'b1; in_valid = 1'b1; z = 11'h52F;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_latency1: got out_valid=%b want 0", out_valid);
    end
    tick();
    checks++;
    if ({out_valid, x, syndrome, err_corr, err_uncorr} !== {1'b1, 7'h55, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clean_word: got v=%b x=%h s=%0d c=%b u=%b want 1 55 0 0 0",
               out_valid, x, syndrome, err_corr, err_uncorr);
    end
    tick();
    checks++;
    if ({out_valid, cnt_corr, cnt_uncorr} !== {1'b0, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL clean_drain: got v=%b cnt=%0d/%0d want 0 0/0", out_valid, cnt_corr, cnt_uncorr);
    end
  endtask

  task automatic test_corrected();
    push_word(11'h50F);
    checks++;
    if ({out_valid, x, syndrome, err_corr, err_uncorr} !== {1'b1, 7'h55, 4'd6, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL corr_word: got v=%b x=%h s=%0d c=%b u=%b want 1 55 6 1 0",
               out_valid, x, syndrome, err_corr, err_uncorr);
    end
    tick();
    checks++;
    if (cnt_corr !== 2'd1) begin
      errors++;
      $display("FAIL corr_count: got %0d want 1", cnt_corr);
    end
  endtask

  task automatic test_uncorrectable();
    // 0x52F with positions 11 and 4 flipped
    push_word(11'h127);
    checks++;
    if ({x, syndrome, err_corr, err_uncorr} !== {7'h15, 4'd15, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL uncorr_s15: got x=%h s=%0d c=%b u=%b want 15 15 0 1", x, syndrome, err_corr, err_uncorr);
    end
    tick();
    checks++;
    if (cnt_uncorr !== 2'd1) begin
      errors++;
      $display("FAIL uncorr_count1: got %0d want 1", cnt_uncorr);
    end
    // 0x52F with positions 9 and 4 flipped: syndrome 13
    push_word(11'h427);
    checks++;
    if ({x, syndrome, err_corr, err_uncorr} !== {7'h45, 4'd13, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL uncorr_s13: got x=%h s=%0d c=%b u=%b want 45 13 0 1", x, syndrome, err_corr, err_uncorr);
    end
    tick();
    checks++;
    if ({cnt_uncorr, cnt_corr} !== {2'd2, 2'd1}) begin
      errors++;
      $display("FAIL uncorr_count2: got u=%0d c=%0d want 2 1", cnt_uncorr, cnt_corr);
    end
  endtask

  task automatic test_miscorrection();
    push_word(11'h52C);
    checks++;
    if ({x, syndrome, err_corr, err_uncorr} !== {7'h54, 4'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL miscorr_word: got x=%h s=%0d c=%b u=%b want 54 3 1 0", x, syndrome, err_corr, err_uncorr);
    end
    tick();
    checks++;
    if (cnt_corr !== 2'd2) begin
      errors++;
      $display("FAIL miscorr_count: got %0d want 2", cnt_corr);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:1] zw [4];
    logic [7:1]  ex [4];
    logic [7:1]  held;
    logic        held_vld;
    int sent, rcv, stalls;
    zw[0] = 11'h52F; ex[0] = 7'h55;
    zw[1] = 11'h000; ex[1] = 7'h00;
    zw[2] = 11'h7FF; ex[2] = 7'h7F;
    zw[3] = 11'h52C; ex[3] = 7'h54;
    sent = 0; rcv = 0; stalls = 0; held = '0; held_vld = 1'b0;
    for (int c = 0; c < 30 && rcv < 4; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 4);
      z         = (sent < 4) ? zw[sent] : 11'h000;
      #1;
      if (!out_ready) begin
        stalls++;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_stall_ready c=%0d: got rdy=%b v=%b want 0 1", c, in_ready, out_valid);
        end
        if (held_vld) begin
          checks++;
          if (x !== held) begin
            errors++;
            $display("FAIL bp_hold c=%0d: got x=%h want %h", c, x, held);
          end
        end
        held = x;
        held_vld = out_valid;
      end else begin
        held_vld = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (x !== ex[rcv]) begin
          errors++;
          $display("FAIL bp_order[%0d]: got x=%h want %h", rcv, x, ex[rcv]);
        end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (sent !== 4 || rcv !== 4 || stalls !== 3) begin
      errors++;
      $display("FAIL bp_counts: got sent=%0d rcv=%0d stalls=%0d want 4 4 3", sent, rcv, stalls);
    end
    checks++;
    if (out_valid !== 1'b0 || cnt_corr !== 2'd3) begin
      errors++;
      $display("FAIL bp_drain: got v=%b cnt_corr=%0d want 0 3", out_valid, cnt_corr);
    end
  endtask

  task automatic test_saturation_clear();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    z = 11'h50F;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({out_valid, cnt_corr, cnt_uncorr} !== {1'b0, 2'd3, 2'd0}) begin
      errors++;
      $display("FAIL sat_count: got v=%b cnt=%0d/%0d want 0 3/0", out_valid, cnt_corr, cnt_uncorr);
    end
    push_word(11'h50F);
    checks++;
    if (out_valid !== 1'b1 || err_corr !== 1'b1 || cnt_corr !== 2'd3) begin
      errors++;
      $display("FAIL sat_hold: got v=%b c=%b cnt=%0d want 1 1 3", out_valid, err_corr, cnt_corr);
    end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks++;
    if (cnt_corr !== 2'd0) begin
      errors++;
      $display("FAIL clr_priority: got %0d want 0", cnt_corr);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    z         = 11'h50F;
    tick();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || cnt_corr !== 2'd1) begin
      errors++;
      $display("FAIL mid_stream: got v=%b cnt=%0d want 1 1", out_valid, cnt_corr);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({out_valid, in_ready, x, err_corr, syndrome, cnt_corr} !== {1'b0, 1'b1, 7'h00, 1'b0, 4'd0, 2'd0}) begin
      errors++;
      $display("FAIL mid_reset: got v=%b rdy=%b x=%h c=%b s=%0d cnt=%0d want 0 1 00 0 0 0",
               out_valid, in_ready, x, err_corr, syndrome, cnt_corr);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_flush: got out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_corrected();
    test_uncorrectable();
    test_miscorrection();
    test_back_to_back();
    test_saturation_clear();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
